// File: rtl/dff_pkg.sv
// Shared helpers for the dff storage element: the per-bit next-state priority mux.
package dff_pkg;

    // Priority, highest first: reset, clear, preset, data. Clear beats preset.
    function automatic logic next_bit(input logic rst, input logic rst_val, input logic clr_b,
                                      input logic pr_b, input logic d);
        logic nxt;
        if (rst) begin
            nxt = rst_val;
        end else if (!clr_b) begin
            nxt = 1'b0;
        end else if (!pr_b) begin
            nxt = 1'b1;
        end else begin
            nxt = d;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/dff_if.sv
// Data/control bundle of a WIDTH-bit dff; master drives d/pr_b/clr_b, slave returns q/q_b.
interface dff_if #(
    parameter int unsigned WIDTH = 1
);
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] pr_b;
    logic [WIDTH-1:0] clr_b;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_b;

    modport master (output d, output pr_b, output clr_b, input q, input q_b);
    modport slave (input d, input pr_b, input clr_b, output q, output q_b);
endinterface

// File: rtl/dff.sv
// WIDTH-bit rising-edge D flip-flop with per-bit synchronous active-low preset/clear,
// synchronous active-high reset and a combinational complement output.
module dff
    import dff_pkg::*;
#(
    parameter int unsigned     WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic  clk,
    input  logic  rst,
    dff_if.slave  bus
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        for (int i = 0; i < WIDTH; i++) begin
            q_d[i] = next_bit(rst, RST_VAL[i], bus.clr_b[i], bus.pr_b[i], bus.d[i]);
        end
    end

    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign bus.q   = q_q;
    assign bus.q_b = ~q_q;

endmodule

// File: tb/tb_dff.sv
// Directed self-checking bench for dff: a 1-bit instance and a 4-bit instance with RST_VAL=1010.
module tb_dff;

    logic clk;
    logic rst1;
    logic rst4;
    int   n_checks;
    int   n_fail;

    dff_if #(.WIDTH(1)) bus1 ();
    dff_if #(.WIDTH(4)) bus4 ();

    dff #(
        .WIDTH   (1),
        .RST_VAL (1'b0)
    ) u_dff1 (
        .clk (clk),
        .rst (rst1),
        .bus (bus1)
    );

    dff #(
        .WIDTH   (4),
        .RST_VAL (4'b1010)
    ) u_dff4 (
        .clk (clk),
        .rst (rst4),
        .bus (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst4      = 1'b0;
        bus4.d     = '0;
        bus4.pr_b  = '1;
        bus4.clr_b = '1;

        // 1. Reset
        rst1 = 1'b1; bus1.d = 1'b1; bus1.pr_b = 1'b1; bus1.clr_b = 1'b1;
        tick();
        check("rst_q", 4'(bus1.q), 4'b0);
        check("rst_qb", 4'(bus1.q_b), 4'b1);
        rst1 = 1'b0;
        tick();
        check("post_rst_q", 4'(bus1.q), 4'b1);

        // 2. Data capture, including a mid-cycle change of d
        bus1.d = 1'b0;
        tick();
        check("cap0_q", 4'(bus1.q), 4'b0);
        bus1.d = 1'b1;
        @(negedge clk);
        check("hold_mid_cycle", 4'(bus1.q), 4'b0);
        tick();
        check("cap1_q", 4'(bus1.q), 4'b1);
        bus1.d = 1'b0;
        tick();
        check("cap2_q", 4'(bus1.q), 4'b0);
        bus1.d = 1'b1;
        tick();
        check("cap3_q", 4'(bus1.q), 4'b1);

        // 3. Preset
        bus1.pr_b = 1'b0; bus1.d = 1'b0;
        tick();
        check("pre_q", 4'(bus1.q), 4'b1);
        check("pre_qb", 4'(bus1.q_b), 4'b0);
        bus1.d = 1'b1;
        tick();
        check("pre_hold_q", 4'(bus1.q), 4'b1);
        bus1.pr_b = 1'b1; bus1.d = 1'b0;
        tick();
        check("pre_rel_q", 4'(bus1.q), 4'b0);

        // 4. Clear
        bus1.d = 1'b1;
        tick();
        bus1.clr_b = 1'b0; bus1.d = 1'b1;
        tick();
        check("clr_q", 4'(bus1.q), 4'b0);
        check("clr_qb", 4'(bus1.q_b), 4'b1);
        bus1.d = 1'b0;
        tick();
        check("clr_d0_q", 4'(bus1.q), 4'b0);
        bus1.d = 1'b1;
        tick();
        check("clr_d1_q", 4'(bus1.q), 4'b0);

        // 5. Priority: clear over preset, reset over preset
        bus1.clr_b = 1'b1; bus1.pr_b = 1'b1; bus1.d = 1'b1;
        tick();
        check("prio_setup_q", 4'(bus1.q), 4'b1);
        bus1.pr_b = 1'b0; bus1.clr_b = 1'b0;
        tick();
        check("prio_clr_q", 4'(bus1.q), 4'b0);
        check("prio_clr_qb", 4'(bus1.q_b), 4'b1);
        rst1 = 1'b1; bus1.clr_b = 1'b1;
        tick();
        check("prio_rst_q", 4'(bus1.q), 4'b0);
        rst1 = 1'b0;
        tick();
        check("prio_pre_q", 4'(bus1.q), 4'b1);

        // X on d propagates when no control is active
        bus1.pr_b = 1'b1; bus1.d = 1'bx;
        tick();
        check("x_prop_q", 4'(bus1.q), 4'b000x);

        // 6. Per-bit control on the 4-bit instance
        rst4 = 1'b1; bus4.d = 4'b0110; bus4.pr_b = 4'b1110; bus4.clr_b = 4'b0111;
        tick();
        check("w4_rst_q", bus4.q, 4'b1010);
        check("w4_rst_qb", bus4.q_b, 4'b0101);
        rst4 = 1'b0;
        tick();
        check("w4_mix_q", bus4.q, 4'b0111);
        check("w4_mix_qb", bus4.q_b, 4'b1000);
        bus4.pr_b = 4'b1111; bus4.clr_b = 4'b1111; bus4.d = 4'b1001;
        tick();
        check("w4_data_q", bus4.q, 4'b1001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dff.md
Name: dff

Overview:
- Positive-edge-triggered D flip-flop with active-low preset (pr_b), active-low clear (clr_b) and complementary outputs.
- Base storage element for the timer/counter datapath. Counter stages instantiate it per bit, or as a WIDTH-bit register.
- Fully synchronous single-clock design. Every state change happens on the rising edge of clk.

Parameters:
- WIDTH, 1, number of independent flip-flop bits; d, pr_b, clr_b, q and q_b are all WIDTH wide.
- RST_VAL, {WIDTH{1'b0}}, value loaded into q by rst.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset; loads RST_VAL.
- d  input  WIDTH  data input, sampled on the rising clk edge.
- pr_b  input  WIDTH  per-bit active-low preset; sets the bit to 1 at the edge.
- clr_b  input  WIDTH  per-bit active-low clear; sets the bit to 0 at the edge.
- q  output  WIDTH  registered state.
- q_b  output  WIDTH  complement of q.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- All controls (rst, pr_b, clr_b) are sampled only at the rising edge of clk. Nothing is asynchronous.
- Per-bit priority at each rising edge, highest first:
  1. rst=1 -> q[i] <= RST_VAL[i]
  2. clr_b[i]=0 -> q[i] <= 0
  3. pr_b[i]=0 -> q[i] <= 1
  4. otherwise -> q[i] <= d[i]
- Simultaneous pr_b=0 and clr_b=0 on the same bit: clear wins, so q=0 and q_b=1. The forbidden-state condition is thereby defined.
- Latency is one cycle from sampled input to q. Between edges, q holds its value regardless of input changes.
- q_b is combinational: q_b = ~q at all times, including during reset. It is never equal to q.
- Reset state: q=RST_VAL and q_b=~RST_VAL after the first rising edge with rst=1.
- Before the first reset or control edge, q is undefined (X in simulation). The bench must apply rst or clr_b before checking outputs.
- X or Z on d with pr_b=clr_b=1 propagates to q. X on a control input is not checked.
- No internal state other than q. There is no enable; a hold is achieved by feeding q back to d externally.

Decomposition:
- No shared package needed. RST_VAL is the only constant and it is a parameter.
- No sub-module. A single always block for q plus a continuous assignment for q_b.
- The bit-level priority mux may be written as a function inside the module.

Test Plan:
1. Reset: rst=1, d=1, pr_b=1, clr_b=1 for 1 edge -> q=0, q_b=1. Deassert rst, hold d=1 -> q=1 after the next edge.
2. Data capture: pr_b=1, clr_b=1, d toggling 0,1,0,1 each cycle -> q follows d delayed by exactly 1 edge. d changes mid-cycle do not affect q until the next edge.
3. Preset: pr_b=0, clr_b=1, d=0 -> q=1 and q_b=1'b0 at the next edge. Presetting persists with d=1. Release pr_b with d=0 -> q=0 the following edge.
4. Clear: clr_b=0, pr_b=1, d=1 -> q=0 and q_b=1 at the next edge. q stays 0 for the d=0 and d=1 cycles while clr_b=0.
5. Priority: pr_b=0, clr_b=0 -> q=0. Then rst=1 with pr_b=0 and clr_b=1 -> q=RST_VAL (0). Then rst=0 -> q=1.
6. Width and per-bit control: WIDTH=4, RST_VAL=4'b1010, d=4'b0110, pr_b=4'b1110, clr_b=4'b0111.
   - After rst -> q=4'b1010.
   - Next edge -> q=4'b0111 (bit3 cleared, bit0 preset, bits 2..1 from d), q_b=4'b1000.
